seg7_capture: RTL and testbench

Seven-segment pattern decoder/capture block: the receiving end of the ALU's `segments` output. It watches a 7-bit segment bus and waits for each pattern to hold steady. It then decodes the pattern back to a hex nibble and queues it in a small FIFO for a host or checker to read over a valid/ready handshake. It sits on the ALU output path in board-level and self-check builds, turning `uo_out[6:0]` back into result values.

---
 rtl/seg7_capture.sv | 180 ++++++++++++++++++
 tb/tb_seg7_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Seven-segment capture: debounce, decode and queue hex nibbles.
// Optional error counter built when SEG7_CAPTURE_ERRCNT_EN is defined.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] segments_in,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  input  logic       clr,
  output logic [7:0] err_count
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    r_sreg;
  logic [RW-1:0] r_run;
  logic [6:0]    r_last;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [3:0]    r_out;
  logic          r_ovf;

  logic       w_hit;
  logic [3:0] w_nib;
  logic       w_accept;
  logic       w_blank;
  logic       w_new;
  logic       w_full;
  logic       w_pop;
  logic       w_push;

  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (r_sreg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  // run saturates at STABLE_CYCLES, so this fires once per held pattern
  assign w_accept = ena && (r_run == RW'(STABLE_CYCLES - 1));
  assign w_blank  = (r_sreg == 7'h00);
  assign w_new    = w_accept && w_hit && (r_sreg != r_last);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = out_valid && out_ready;
  assign w_push   = w_new && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= 7'h00;
      r_run  <= '0;
      r_last <= 7'h00;
    end else begin
      if (ena) begin
        r_sreg <= segments_in;
        if (segments_in != r_sreg) begin
          r_run <= '0;
        end else if (r_run != RW'(STABLE_CYCLES)) begin
          r_run <= r_run + RW'(1);
        end
      end
      if (clr) begin
        r_last <= 7'h00;
      end else if (w_accept) begin
        if (w_blank) begin
          r_last <= 7'h00;
        end else if (w_hit) begin
          r_last <= r_sreg;
`ifdef SEG7_CAPTURE_ERRCNT_EN
        end else begin
          r_last <= 7'h00;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 4'h0;
      end
    end else if (w_push && !clr) begin
      r_mem[r_wr] <= w_nib;
    end
  end

  // head register refills from the next slot on pop: no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_out   <= 4'h0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_out   <= 4'h0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_pop) begin
        if (r_count > CW'(1)) begin
          r_out <= r_mem[r_rd + AW'(1)];
        end else if (w_push) begin
          r_out <= w_nib;
        end
      end else if (w_push && r_count == '0) begin
        r_out <= w_nib;
      end
      if (w_new && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_data  = r_out;
  assign out_valid = (r_count != '0);
  assign overflow  = r_ovf;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] r_err;
  logic       w_bad;

  assign w_bad = w_accept && !w_hit && !w_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 8'h00;
    end else if (clr) begin
      r_err <= 8'h00;
    end else if (w_bad && r_err != 8'hFF) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign err_count = r_err;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture.
// Pops are logged by a monitor just ahead of each rising edge.
module tb_seg7_capture;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [6:0] segments_in;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       clr;
  logic [7:0] err_count;

  int n_vec;
  int n_err;
  logic [3:0] q[$];

`ifdef SEG7_CAPTURE_ERRCNT_EN
  localparam logic [7:0] ERR_ONE = 8'h01;
`else
  localparam logic [7:0] ERR_ONE = 8'h00;
`endif

  seg7_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .segments_in (segments_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .clr         (clr),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      q.push_back(out_data);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] pat,
                      input int n);
    segments_in = pat;
    tick(n);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  logic [6:0] fill_a [4];
  logic [6:0] fill_b [4];
  logic [3:0] exp_b  [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    fill_a = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    fill_b = '{7'h7F, 7'h6F, 7'h77, 7'h7C};
    exp_b  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h6};
    rst_n = 1'b0;
    ena = 1'b1;
    segments_in = 7'h00;
    out_ready = 1'b0;
    clr = 1'b0;
    tick(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single digit 2, latency
    segments_in = 7'h5B;
    tick(4);
    chk("t1_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'd2);
    tick(1);
    segments_in = 7'h00;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("t1_one", 32'(out_valid), 32'd0);
    chk("t1_pops", 32'(q.size()), 32'd1);
    chk("t1_pop0", 32'(q[0]), 32'd2);
    tick(5);
    pulse_clr();

    // repeat after blank re-arms; long hold counted once
    q.delete();
    out_ready = 1'b1;
    hold(7'h3F, 6);
    hold(7'h00, 6);
    hold(7'h3F, 6);
    chk("t2_pops", 32'(q.size()), 32'd2);
    chk("t2_d0", 32'(q[0]), 32'd0);
    chk("t2_d1", 32'(q[1]), 32'd0);
    hold(7'h00, 6);
    q.delete();
    hold(7'h3F, 20);
    chk("t2_long", 32'(q.size()), 32'd1);

    // short 0 glitch then held 1
    hold(7'h00, 6);
    q.delete();
    hold(7'h3F, 2);
    hold(7'h06, 7);
    chk("t3_pops", 32'(q.size()), 32'd1);
    chk("t3_d0", 32'(q[0]), 32'd1);
    out_ready = 1'b0;

    // invalid stable pattern
    hold(7'h55, 6);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_err", 32'(err_count), 32'(ERR_ONE));

    // overflow on fifth digit
    hold(7'h00, 6);
    pulse_clr();
    chk("t5_errclr", 32'(err_count), 32'd0);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      hold(fill_a[i], 6);
      hold(7'h00, 6);
    end
    chk("t5_noovf", 32'(overflow), 32'd0);
    hold(7'h6D, 6);
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("t5_pop", 32'(q[0]), 32'd1);
    chk("t5_next", 32'(out_data), 32'd2);
    chk("t5_nvalid", 32'(out_valid), 32'd1);
    pulse_clr();
    chk("t5_clrv", 32'(out_valid), 32'd0);
    chk("t5_clro", 32'(overflow), 32'd0);

    // push and pop together on a full fifo
    hold(7'h00, 6);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      hold(fill_b[i], 6);
      hold(7'h00, 6);
    end
    chk("t6_head", 32'(out_data), 32'h8);
    segments_in = 7'h7D;
    tick(4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_next", 32'(out_data), 32'h9);
    out_ready = 1'b1;
    tick(5);
    out_ready = 1'b0;
    chk("t6_pops", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6_d%0d", i), 32'(q[i]), 32'(exp_b[i]));
    end
    chk("t6_empty", 32'(out_valid), 32'd0);

    // reset mid-run
    hold(7'h00, 6);
    segments_in = 7'h7D;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("t7_rstv", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick(4);
    chk("t7_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("t7_valid", 32'(out_valid), 32'd1);
    chk("t7_data", 32'(out_data), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
